mandel_multi_engine_gen: RTL
============================

Name: mandel_multi_engine_gen

Overview:
Parametrised successor to the single-engine pixel generator. Latches a frame configuration on start, walks the screen in raster order, and computes each pixel's complex coordinate c. Dispatches pixels round-robin to N_ENGINES iteration engines and returns escape depths in strict raster order on a valid/ready stream. The stream feeds the colour-mapping and frame-buffer stage.

Parameters:
WORD_LENGTH, 64, fixed-point word width (signed).
FRAC, 60, fractional bits.
N_ENGINES, 4, parallel iteration engines (>=1).
ITER_W, 10, depth and max_iter width.
X_W, 11, x counter and screen_width width.
Y_W, 11, y counter and screen_height width.

Ports:
sysclk  in  1  clock.
reset_n  in  1  asynchronous active-low reset.
start  in  1  frame start pulse; accepted only when idle.
screen_width  in  X_W  pixels per line; latched at start.
screen_height  in  Y_W  lines per frame; latched at start.
real_center  in  WORD_LENGTH  signed centre real part, Q(WORD_LENGTH-FRAC).FRAC; latched.
imag_center  in  WORD_LENGTH  signed centre imaginary part; latched.
zoom  in  6  pixel step = 2^-(8+zoom); latched; valid range 0..FRAC-8.
max_iter  in  ITER_W  iteration cap; latched.
busy  out  1  frame in progress.
frame_done  out  1  one-cycle pulse at end of frame.
out_valid  out  1  result beat valid.
out_ready  in  1  downstream accept.
out_x  out  X_W  pixel x.
out_y  out  Y_W  pixel y.
out_depth  out  ITER_W  escape depth.
out_sof  out  1  first beat of frame (x=0, y=0).
out_last  out  1  final beat of frame.

Behaviour:
- Reset values: busy=0, frame_done=0, out_valid=0, out_x=0, out_y=0, out_depth=0, out_sof=0, out_last=0. All engines IDLE; dispatch and collect pointers reset to 0.
- Reset mid-frame: all state is discarded immediately and in-flight results are dropped.
- Idle plus start: latch the configuration and set busy on the next edge. start while busy is ignored.
- Zero-size frame (screen_width=0 or screen_height=0): busy for one cycle, then pulse frame_done. No beats are emitted.
- Coordinates:
  - step = 1 << (FRAC-8-zoom).
  - re_c = real_center + (x - (screen_width>>1))*step.
  - im_c = imag_center - (y - (screen_height>>1))*step.
  - Arithmetic is two's complement modulo 2^WORD_LENGTH, with no saturation.
- Dispatch: pixel k goes to engine k mod N_ENGINES. The issue occurs only when that engine is IDLE, i.e. its previous result has been collected. At most one dispatch per cycle. The raster counter advances on each dispatch.
- Collect: result k is taken from engine k mod N_ENGINES once that engine is DONE and the output register is empty or being drained. This gives strict raster order with no reorder buffer.
- Output stream:
  - Once out_valid is asserted, all out_* fields hold stable until out_valid&&out_ready.
  - Backpressure stalls collection. Engines then hold DONE, which in turn stalls dispatch.
  - Throughput is at most 1 beat per cycle.
- Frame end: after the handshake of the out_last beat, frame_done pulses on the next cycle and busy falls on that same cycle.
- Engine state machine:
  - IDLE -> ITER on dispatch: load c, z=0, n=0.
  - ITER, one step per cycle: if |z|^2 > 4 or n==max_iter -> DONE with depth=n. Otherwise zr'=zr^2-zi^2+cr, zi'=2*zr*zi+ci, n++.
  - DONE -> IDLE on collect.
- Engine arithmetic:
  - Products are formed at 2*WORD_LENGTH and shifted right by FRAC (arithmetic) to WORD_LENGTH.
  - The magnitude compare uses the untruncated products (2*WORD_LENGTH+1 bits) against 4<<(2*FRAC).
- Latency: escape at |c|>2 gives depth 1 after 2 ITER cycles. A non-escaping c occupies max_iter+1 ITER cycles. max_iter=0 gives depth 0 for every pixel.

Optional Feature:
Macro MANDEL_PERF_CNT_EN.
- Defined: adds outputs frame_cycles[31:0] (cycles from start-accept to frame_done) and iter_total[47:0] (sum of emitted out_depth values). Both clear on start-accept, are valid from frame_done until the next start, and reset to 0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package mandel_pkg holds:
  - fixed-point typedef parametrised by WORD_LENGTH;
  - ESCAPE_RADIUS_SQ constant;
  - engine state enum {IDLE, ITER, DONE};
  - frame config struct;
  - pixel result struct {x, y, depth}.
- Sub-module mandel_iter_engine holds one engine's state machine and arithmetic. The top instantiates N_ENGINES of it via generate.

Test Plan:
- W=1,H=1, centre (0,0), max_iter=20 -> one beat x=0,y=0,depth=20,sof=1,last=1; frame_done pulses once.
- W=1,H=1, centre (2.5,0), max_iter=20 -> depth=1, out_valid within 4 cycles of dispatch.
- W=8,H=4, zoom=0, centre (-0.5,0), N_ENGINES=4, random out_ready -> 32 beats in raster order; sof only at (0,0), last only at (7,3); depths match the golden model.
- max_iter=0, W=4,H=2 -> 8 beats, all depth=0.
- Reset pulsed after the 5th handshake of a W=8,H=4 frame -> out_valid=0 and busy=0 immediately. The next start yields a complete frame from (0,0).
- start held during a busy frame -> ignored, exactly one frame_done. W=0 -> frame_done pulse after 1 busy cycle, no beats.

Source files
------------

// File: rtl/mandel_pkg.sv
// Shared types for the multi-engine Mandelbrot pixel generator: fixed-point word,
// escape threshold, engine state encoding, frame configuration and result beat.
package mandel_pkg;

    localparam int unsigned WORD_LENGTH_P = 64;
    localparam int unsigned FRAC_P        = 60;
    localparam int unsigned ITER_W_P      = 10;
    localparam int unsigned X_W_P         = 11;
    localparam int unsigned Y_W_P         = 11;

    typedef logic signed [WORD_LENGTH_P-1:0] fixed_t;

    // 4.0 at the scale of an untruncated product (2*FRAC fractional bits)
    localparam logic signed [2*WORD_LENGTH_P:0] ESCAPE_RADIUS_SQ =
        {{(2*WORD_LENGTH_P-2){1'b0}}, 3'b100} << (2*FRAC_P);

    typedef enum logic [1:0] {
        EngIdle,
        EngIter,
        EngDone
    } eng_state_e;

    typedef struct packed {
        logic [X_W_P-1:0]    width;
        logic [Y_W_P-1:0]    height;
        fixed_t              real_center;
        fixed_t              imag_center;
        logic [5:0]          zoom;
        logic [ITER_W_P-1:0] max_iter;
    } frame_cfg_t;

    typedef struct packed {
        logic [X_W_P-1:0]    x;
        logic [Y_W_P-1:0]    y;
        logic [ITER_W_P-1:0] depth;
    } pix_result_t;

endpackage

// File: rtl/mandel_multi_engine_gen_engine.sv
// One escape-time iteration engine: IDLE -> ITER (one z^2+c step per cycle) -> DONE,
// holding the depth until the collector takes it.
module mandel_iter_engine
    import mandel_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = WORD_LENGTH_P,
    parameter int unsigned FRAC        = FRAC_P,
    parameter int unsigned ITER_W      = ITER_W_P
) (
    input  logic                          sysclk,
    input  logic                          reset_n,
    input  logic                          load,
    input  logic                          collect,
    input  logic signed [WORD_LENGTH-1:0] c_re,
    input  logic signed [WORD_LENGTH-1:0] c_im,
    input  logic [ITER_W-1:0]             max_iter,
    output logic                          idle,
    output logic                          done,
    output logic [ITER_W-1:0]             depth
);

    localparam int unsigned PW = 2 * WORD_LENGTH;

    eng_state_e state_q, state_d;

    logic signed [WORD_LENGTH-1:0] cr_q, ci_q, zr_q, zi_q, zr_d, zi_d;
    logic [ITER_W-1:0]             n_q, max_q;
    logic signed [PW-1:0]          zr2, zi2, zri, zr2_s, zi2_s, zri_s;
    logic signed [PW:0]            mag;
    logic                          finish;

    assign zr2   = PW'(zr_q) * PW'(zr_q);
    assign zi2   = PW'(zi_q) * PW'(zi_q);
    assign zri   = PW'(zr_q) * PW'(zi_q);
    assign zr2_s = zr2 >>> FRAC;
    assign zi2_s = zi2 >>> FRAC;
    assign zri_s = zri >>> FRAC;

    // Escape test uses the full-precision squares so no truncation error leaks in
    assign mag    = (PW+1)'(zr2) + (PW+1)'(zi2);
    assign finish = (mag > ESCAPE_RADIUS_SQ) || (n_q == max_q);

    assign zr_d = zr2_s[WORD_LENGTH-1:0] - zi2_s[WORD_LENGTH-1:0] + cr_q;
    assign zi_d = {zri_s[WORD_LENGTH-2:0], 1'b0} + ci_q;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EngIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EngIdle: if (load)    state_d = EngIter;
            EngIter: if (finish)  state_d = EngDone;
            EngDone: if (collect) state_d = EngIdle;
            default:              state_d = EngIdle;
        endcase
    end

    always_comb begin
        idle  = (state_q == EngIdle);
        done  = (state_q == EngDone);
        depth = n_q;
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            cr_q  <= '0;
            ci_q  <= '0;
            zr_q  <= '0;
            zi_q  <= '0;
            n_q   <= '0;
            max_q <= '0;
        end else if (load && (state_q == EngIdle)) begin
            cr_q  <= c_re;
            ci_q  <= c_im;
            zr_q  <= '0;
            zi_q  <= '0;
            n_q   <= '0;
            max_q <= max_iter;
        end else if ((state_q == EngIter) && !finish) begin
            zr_q <= zr_d;
            zi_q <= zi_d;
            n_q  <= n_q + ITER_W'(1);
        end
    end

endmodule

// File: rtl/mandel_multi_engine_gen.sv
// Raster-order Mandelbrot generator: round-robin dispatch to N_ENGINES engines,
// in-order collection onto a valid/ready stream. MANDEL_PERF_CNT_EN adds perf counters.
module mandel_multi_engine_gen
    import mandel_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = WORD_LENGTH_P,
    parameter int unsigned FRAC        = FRAC_P,
    parameter int unsigned N_ENGINES   = 4,
    parameter int unsigned ITER_W      = ITER_W_P,
    parameter int unsigned X_W         = X_W_P,
    parameter int unsigned Y_W         = Y_W_P
) (
    input  logic                          sysclk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [X_W-1:0]                screen_width,
    input  logic [Y_W-1:0]                screen_height,
    input  logic signed [WORD_LENGTH-1:0] real_center,
    input  logic signed [WORD_LENGTH-1:0] imag_center,
    input  logic [5:0]                    zoom,
    input  logic [ITER_W-1:0]             max_iter,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [X_W-1:0]                out_x,
    output logic [Y_W-1:0]                out_y,
    output logic [ITER_W-1:0]             out_depth,
    output logic                          out_sof,
    output logic                          out_last
`ifdef MANDEL_PERF_CNT_EN
    ,
    output logic [31:0]                   frame_cycles,
    output logic [47:0]                   iter_total
`endif
);

    localparam int unsigned PTR_W = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(N_ENGINES - 1);
    localparam logic [6:0] SH_BASE = 7'(FRAC - 8);

    typedef enum logic {
        StIdle,
        StRun
    } top_state_e;

    top_state_e  state_q, state_d;
    frame_cfg_t  cfg_q;
    pix_result_t res_q;
    logic        frame_done_q, frame_done_d;
    logic        out_valid_q, out_sof_q, out_last_q;

    logic start_acc, frame_zero, zero_in, last_hs;
    logic disp_fire, coll_fire;

    logic [X_W-1:0]   x_q, cx_q;
    logic [Y_W-1:0]   y_q, cy_q;
    logic [PTR_W-1:0] disp_ptr_q, coll_ptr_q;
    logic             disp_all_q;
    logic             x_last, y_last, cx_last, cy_last;

    logic              eng_idle    [N_ENGINES];
    logic              eng_done    [N_ENGINES];
    logic [ITER_W-1:0] eng_depth   [N_ENGINES];
    logic              eng_load    [N_ENGINES];
    logic              eng_collect [N_ENGINES];

    logic signed [X_W:0]           dx;
    logic signed [Y_W:0]           dy;
    logic signed [WORD_LENGTH-1:0] dx_ext, dy_ext, re_c, im_c;
    logic [6:0]                    sh;

    assign start_acc  = (state_q == StIdle) && start;
    assign zero_in    = (screen_width == '0) || (screen_height == '0);
    assign frame_zero = (cfg_q.width == '0) || (cfg_q.height == '0);
    assign last_hs    = out_valid_q && out_ready && out_last_q;

    // Top-level frame FSM
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            StIdle: if (start) state_d = StRun;
            StRun: begin
                if (frame_zero || last_hs) begin
                    state_d      = StIdle;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy       = (state_q == StRun);
        frame_done = frame_done_q;
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q <= '0;
        end else if (start_acc) begin
            cfg_q.width       <= screen_width;
            cfg_q.height      <= screen_height;
            cfg_q.real_center <= real_center;
            cfg_q.imag_center <= imag_center;
            cfg_q.zoom        <= zoom;
            cfg_q.max_iter    <= max_iter;
        end
    end

    // Pixel coordinate for the next dispatch: centre + offset * 2^-(8+zoom)
    always_comb begin
        dx     = $signed({1'b0, x_q}) - $signed({1'b0, cfg_q.width >> 1});
        dy     = $signed({1'b0, y_q}) - $signed({1'b0, cfg_q.height >> 1});
        dx_ext = {{(WORD_LENGTH-X_W-1){dx[X_W]}}, dx};
        dy_ext = {{(WORD_LENGTH-Y_W-1){dy[Y_W]}}, dy};
        sh     = SH_BASE - {1'b0, cfg_q.zoom};
        re_c   = cfg_q.real_center + (dx_ext <<< sh);
        im_c   = cfg_q.imag_center - (dy_ext <<< sh);
    end

    assign x_last    = (x_q == cfg_q.width - X_W'(1));
    assign y_last    = (y_q == cfg_q.height - Y_W'(1));
    assign disp_fire = busy && !disp_all_q && eng_idle[disp_ptr_q];

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            x_q        <= '0;
            y_q        <= '0;
            disp_ptr_q <= '0;
            disp_all_q <= 1'b0;
        end else if (start_acc) begin
            x_q        <= '0;
            y_q        <= '0;
            disp_ptr_q <= '0;
            disp_all_q <= zero_in;
        end else if (disp_fire) begin
            disp_ptr_q <= (disp_ptr_q == PTR_MAX) ? '0 : disp_ptr_q + PTR_W'(1);
            if (x_last) begin
                x_q <= '0;
                if (y_last) begin
                    disp_all_q <= 1'b1;
                end else begin
                    y_q <= y_q + Y_W'(1);
                end
            end else begin
                x_q <= x_q + X_W'(1);
            end
        end
    end

    // In-order collection: only the engine owning the next raster pixel is examined
    assign cx_last   = (cx_q == cfg_q.width - X_W'(1));
    assign cy_last   = (cy_q == cfg_q.height - Y_W'(1));
    assign coll_fire = busy && eng_done[coll_ptr_q] && (!out_valid_q || out_ready);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            cx_q       <= '0;
            cy_q       <= '0;
            coll_ptr_q <= '0;
        end else if (start_acc) begin
            cx_q       <= '0;
            cy_q       <= '0;
            coll_ptr_q <= '0;
        end else if (coll_fire) begin
            coll_ptr_q <= (coll_ptr_q == PTR_MAX) ? '0 : coll_ptr_q + PTR_W'(1);
            if (cx_last) begin
                cx_q <= '0;
                cy_q <= cy_q + Y_W'(1);
            end else begin
                cx_q <= cx_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            out_sof_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (coll_fire) begin
            out_valid_q <= 1'b1;
            res_q.x     <= cx_q;
            res_q.y     <= cy_q;
            res_q.depth <= eng_depth[coll_ptr_q];
            out_sof_q   <= (cx_q == '0) && (cy_q == '0);
            out_last_q  <= cx_last && cy_last;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = res_q.x;
    assign out_y     = res_q.y;
    assign out_depth = res_q.depth;
    assign out_sof   = out_sof_q;
    assign out_last  = out_last_q;

    for (genvar g = 0; g < N_ENGINES; g++) begin : g_eng
        assign eng_load[g]    = disp_fire && (disp_ptr_q == PTR_W'(g));
        assign eng_collect[g] = coll_fire && (coll_ptr_q == PTR_W'(g));

        mandel_iter_engine #(
            .WORD_LENGTH(WORD_LENGTH),
            .FRAC       (FRAC),
            .ITER_W     (ITER_W)
        ) u_engine (
            .sysclk  (sysclk),
            .reset_n (reset_n),
            .load    (eng_load[g]),
            .collect (eng_collect[g]),
            .c_re    (re_c),
            .c_im    (im_c),
            .max_iter(cfg_q.max_iter),
            .idle    (eng_idle[g]),
            .done    (eng_done[g]),
            .depth   (eng_depth[g])
        );
    end

`ifdef MANDEL_PERF_CNT_EN
    logic [31:0] cyc_q;
    logic [47:0] itot_q;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q  <= '0;
            itot_q <= '0;
        end else if (start_acc) begin
            cyc_q  <= '0;
            itot_q <= '0;
        end else begin
            if (busy) cyc_q <= cyc_q + 32'd1;
            if (out_valid_q && out_ready) itot_q <= itot_q + 48'(res_q.depth);
        end
    end

    assign frame_cycles = cyc_q;
    assign iter_total   = itot_q;
`endif

endmodule
